pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (F, D, E, M, W). It drives the stall and flush enables of the F/D, D/E and E/M segment registers and the E-stage operand forwarding selects. It sequences three kinds of pipeline events:
- load-use and RAW interlocks;
- taken-branch squash;
- multi-cycle data-memory waits, guarded by a watchdog.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- CNT_W, 16, width of the stall-cycle counter.
- BR_PENALTY, 1, cycles of D-stage flush per taken branch (legal range 1..4).
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before the watchdog fires (legal range 2..255).
- clk  in  1  pipeline clock; all state updates on the falling edge, the same edge as the segment registers.
- rst  in  1  reset, asynchronous, active-high.
- RA1D, RA2D  in  4  source register addresses in D.
- RA1E, RA2E  in  4  source register addresses in E.
- WA3E, WA3M, WA3W  in  4  destination register addresses in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination valid in E, M and W.
- MemtoRegE  in  1  the instruction in E is a load.
- BranchTakenE  in  1  branch resolved taken in E.
- mem_req  in  1  M stage is performing a data-memory access.
- mem_ready  in  1  memory completes the access this cycle.
- stat_clr  in  1  synchronous clear of stall_count.
- StallF, StallD, StallE, StallM  out  1  hold the PC and the F/D, D/E and E/M registers.
- FlushD, FlushE  out  1  zero the F/D and D/E registers.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W result, 10 M ALU result.
- stall_count  out  CNT_W  stall cycles since reset or clear; saturates at all-ones.
- mem_err  out  1  sticky watchdog flag.

## Operation
- FSM states:
  - RUN: normal operation.
  - BRFLUSH: extra fetch-squash cycles after a taken branch.
  - MEMWAIT: pipeline frozen on memory.
- Priority, highest first: rst > memory wait > taken branch > load-use/RAW interlock.
- memwait = mem_req & ~mem_ready & ~mem_err. It asserts StallF, StallD, StallE and StallM. No flushes are issued while it is asserted. BranchTakenE is ignored because E is held.
- RUN → MEMWAIT on memwait.
- MEMWAIT → RUN on the edge where mem_ready=1. Stalls are already low in that cycle.
- Watchdog:
  - Counts consecutive memwait cycles.
  - On reaching MEM_TIMEOUT it sets mem_err and returns to RUN.
  - mem_err forces memwait low until rst (fault release, not a completed access).
- Branch (RUN, BranchTakenE=1):
  - FlushD=FlushE=1 in the same cycle.
  - If BR_PENALTY>1, go to BRFLUSH with a down-counter of BR_PENALTY-1.
  - BRFLUSH asserts FlushD only, decrementing each cycle, and returns to RUN at 0.
  - A new BranchTakenE in BRFLUSH reloads the counter.
- Interlock condition ldstall: MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- Interlock response: StallF=StallD=1, FlushE=1, with no state change.
- An interlock coinciding with a taken branch is suppressed, because the D instruction is squashed.
- Forwarding:
  - ForwardAE=10 if RegWriteM & WA3M==RA1E.
  - Otherwise ForwardAE=01 if RegWriteW & WA3W==RA1E.
  - Otherwise ForwardAE=00.
  - ForwardBE follows the same rules with RA2E.
  - M takes priority over W.
- stall_count increments on every falling edge where StallF=1.
  - Increment sources: memwait, ldstall, RAW.
  - stat_clr has priority over increment.
  - The counter holds at 2^CNT_W-1.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and current state. They are valid before the next falling edge.
- ldstall produces exactly one bubble in E. The consumer reaches E one cycle later with ForwardxE=01.
- A taken branch costs BR_PENALTY+1 squashed slots: D and E in the resolve cycle, then BR_PENALTY-1 further D slots.
- Memory wait costs N stalled cycles for mem_ready arriving N cycles after mem_req. mem_ready together with mem_req gives zero stall.
- Reset behaviour:
  - While rst=1, all stall/flush outputs are 0, forwards are 00, state is RUN, and the counters are 0.
  - mem_err is cleared.
  - rst asserted mid-MEMWAIT or mid-BRFLUSH abandons the sequence immediately.

## Configuration
- HAZARD_FWD_EN defined: forwarding logic as above.
- HAZARD_FWD_EN undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - The interlock becomes a RAW stall: StallF=StallD=FlushE=1 while RA1D or RA2D matches WA3E (with RegWriteE) or WA3M (with RegWriteM).
  - W needs no stall because the register file writes in the first half-cycle.
  - The RAW stall repeats each cycle until the writer leaves M.

## Test plan
- Load r3 followed immediately by add r4,r3,r3 → one cycle of StallF/StallD/FlushE, then ForwardAE=ForwardBE=01; stall_count=1.
- ALU writes r2 in M and r2 in W, with RA1E=2 → ForwardAE=10 (M priority). With RegWriteM=0 → 01.
- BR_PENALTY=3, BranchTakenE pulse → cycle 0 FlushD=FlushE=1; cycles 1–2 FlushD=1 only; then RUN.
- mem_req with mem_ready after 5 cycles, with BranchTakenE=1 and ldstall conditions also present → 5 cycles of all four stalls and no flush; the branch flush follows on release.
- MEM_TIMEOUT=4, mem_ready never asserted → 4 stall cycles, mem_err=1, stalls drop; rst clears mem_err and stall_count.
- HAZARD_FWD_EN undefined, add r1 then sub r5,r1,r1 → 2 stall cycles; forwards stay 00.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side register addresses, write enables and
// memory handshake in; segment stall/flush/forward controls and statistics out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       RA1D, RA2D, RA1E, RA2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, BranchTakenE;
  logic             mem_req, mem_ready, stat_clr;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_count;
  logic             mem_err;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
    output mem_req, mem_ready, stat_clr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  ForwardAE, ForwardBE, stall_count, mem_err
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
    input  mem_req, mem_ready, stat_clr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
    output ForwardAE, ForwardBE, stall_count, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipeline; state updates on the falling edge.
// Define HAZARD_FWD_EN for E-stage forwarding; otherwise RAW hazards stall until the writer leaves M.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN = 2'd0, BRFLUSH = 2'd1, MEMWAIT = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       br_cnt_r, br_cnt_nxt_s;
  logic [7:0]       wd_cnt_r;
  logic             mem_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             memwait_s, hazard_s, wd_hit_s;
  logic             stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_d_s, flush_e_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  assign memwait_s = hz.mem_req & ~hz.mem_ready & ~mem_err_r;
  assign wd_hit_s  = (wd_cnt_r == 8'(MEM_TIMEOUT - 1));

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic we_m,
                                         input logic [3:0] wa_m, input logic we_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    if (we_m && (wa_m == ra)) begin
      sel = 2'b10;
    end else if (we_w && (wa_w == ra)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign hazard_s = hz.MemtoRegE & hz.RegWriteE &
                    ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));
  assign fwd_a_s  = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
  assign fwd_b_s  = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
`else
  // W never needs a stall: the register file writes in the first half-cycle.
  assign hazard_s = (hz.RegWriteE & ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D))) |
                    (hz.RegWriteM & ((hz.WA3M == hz.RA1D) | (hz.WA3M == hz.RA2D)));
  assign fwd_a_s  = 2'b00;
  assign fwd_b_s  = 2'b00;
`endif

  // Next-state and stall/flush decode: memory wait > taken branch > squash tail > interlock.
  always_comb begin
    state_nxt_s  = state_r;
    br_cnt_nxt_s = br_cnt_r;
    stall_f_s    = 1'b0;
    stall_d_s    = 1'b0;
    stall_e_s    = 1'b0;
    stall_m_s    = 1'b0;
    flush_d_s    = 1'b0;
    flush_e_s    = 1'b0;
    if (rst) begin
      state_nxt_s  = RUN;
      br_cnt_nxt_s = 3'd0;
    end else if (memwait_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      // A frozen squash sequence keeps its remaining slots for after the wait.
      if (state_r == BRFLUSH) begin
        state_nxt_s = BRFLUSH;
      end else if (wd_hit_s) begin
        state_nxt_s = RUN;
      end else begin
        state_nxt_s = MEMWAIT;
      end
    end else if (hz.BranchTakenE) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
      if (BR_PENALTY > 1) begin
        state_nxt_s  = BRFLUSH;
        br_cnt_nxt_s = 3'(BR_PENALTY - 1);
      end else begin
        state_nxt_s  = RUN;
        br_cnt_nxt_s = 3'd0;
      end
    end else begin
      case (state_r)
        BRFLUSH: begin
          // D holds a squashed slot, so no interlock is raised here.
          flush_d_s    = 1'b1;
          br_cnt_nxt_s = br_cnt_r - 3'd1;
          state_nxt_s  = (br_cnt_r == 3'd1) ? RUN : BRFLUSH;
        end
        default: begin
          stall_f_s   = hazard_s;
          stall_d_s   = hazard_s;
          flush_e_s   = hazard_s;
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM state and branch squash down-counter.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      br_cnt_r <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      br_cnt_r <= br_cnt_nxt_s;
    end
  end

  // Memory watchdog: consecutive wait cycles, sticky error on expiry.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r  <= 8'd0;
      mem_err_r <= 1'b0;
    end else if (memwait_s) begin
      if (wd_hit_s) begin
        wd_cnt_r  <= 8'd0;
        mem_err_r <= 1'b1;
      end else begin
        wd_cnt_r  <= wd_cnt_r + 8'd1;
      end
    end else begin
      wd_cnt_r <= 8'd0;
    end
  end

  // Saturating stall-cycle statistic; clear wins over increment.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hz.stat_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_f_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.StallF      = stall_f_s;
  assign hz.StallD      = stall_d_s;
  assign hz.StallE      = stall_e_s;
  assign hz.StallM      = stall_m_s;
  assign hz.FlushD      = flush_d_s;
  assign hz.FlushE      = flush_e_s;
  assign hz.ForwardAE   = rst ? 2'b00 : fwd_a_s;
  assign hz.ForwardBE   = rst ? 2'b00 : fwd_b_s;
  assign hz.stall_count = stall_cnt_r;
  assign hz.mem_err     = mem_err_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a rule-level model queues the expected
// outputs per cycle, and a monitor compares them mid-cycle against the DUT.
module tb_pipe_hazard_ctrl;
  localparam int CW  = 4;
  localparam int BRP = 3;
  localparam int MTO = 8;

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, m2r, br, req, rdy, clr;
  } vec_t;

  typedef struct packed {
    logic [3:0]    stl;  // {F,D,E,M}
    logic [1:0]    fl;   // {D,E}
    logic [1:0]    fa, fb;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.CNT_W(CW), .BR_PENALTY(BRP), .MEM_TIMEOUT(MTO)) dut (
    .clk(clk), .rst(rst), .hz(bus)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference-model state
  int m_wait = 0, m_squash = 0, m_cnt = 0;
  bit m_err = 1'b0;

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [3:0] ra, input vec_t v);
`ifdef HAZARD_FWD_EN
    if (v.rwm && v.wa3m == ra) return 2'b10;
    if (v.rww && v.wa3w == ra) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit m_haz(input vec_t v);
    bit de = (v.wa3e == v.ra1d) || (v.wa3e == v.ra2d);
    bit dm = (v.wa3m == v.ra1d) || (v.wa3m == v.ra2d);
`ifdef HAZARD_FWD_EN
    return v.m2r && v.rwe && de;
`else
    return (v.rwe && de) || (v.rwm && dm);
`endif
  endfunction

  // one cycle: drive at the rising edge, queue the expectation, advance the model to the falling edge
  task automatic apply(input vec_t v, input bit r);
    exp_t e;
    bit mw;
    @(posedge clk);
    rst = r;
    bus.RA1D = v.ra1d; bus.RA2D = v.ra2d; bus.RA1E = v.ra1e; bus.RA2E = v.ra2e;
    bus.WA3E = v.wa3e; bus.WA3M = v.wa3m; bus.WA3W = v.wa3w;
    bus.RegWriteE = v.rwe; bus.RegWriteM = v.rwm; bus.RegWriteW = v.rww;
    bus.MemtoRegE = v.m2r; bus.BranchTakenE = v.br;
    bus.mem_req = v.req; bus.mem_ready = v.rdy; bus.stat_clr = v.clr;
    e = '0;
    if (r) begin
      m_wait = 0; m_squash = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      e.cnt = CW'(m_cnt);
      e.err = m_err;
      e.fa  = m_fwd(v.ra1e, v);
      e.fb  = m_fwd(v.ra2e, v);
      mw = v.req && !v.rdy && !m_err;
      if (mw) begin
        e.stl = 4'b1111;
        m_wait++;
        if (m_wait == MTO) begin m_err = 1'b1; m_wait = 0; end
      end else begin
        m_wait = 0;
        if (v.br) begin
          e.fl = 2'b11; m_squash = BRP - 1;
        end else if (m_squash > 0) begin
          e.fl = 2'b10; m_squash--;
        end else if (m_haz(v)) begin
          e.stl = 4'b1100; e.fl = 2'b01;
        end
      end
      if (v.clr) m_cnt = 0;
      else if (e.stl[3] && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    q.push_back(e);
  endtask

  // monitor: outputs are settled 3 time units after the inputs change
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("stalls",  int'({bus.StallF, bus.StallD, bus.StallE, bus.StallM}), int'(e.stl));
      cmp("flushes", int'({bus.FlushD, bus.FlushE}), int'(e.fl));
      cmp("fwd",     int'({bus.ForwardAE, bus.ForwardBE}), int'({e.fa, e.fb}));
      cmp("count",   int'(bus.stall_count), int'(e.cnt));
      cmp("mem_err", int'(bus.mem_err), int'(e.err));
    end
  end

  function automatic vec_t rand_vec();
    vec_t v;
    v.ra1d = 4'($urandom_range(3, 0)); v.ra2d = 4'($urandom_range(3, 0));
    v.ra1e = 4'($urandom_range(3, 0)); v.ra2e = 4'($urandom_range(3, 0));
    v.wa3e = 4'($urandom_range(3, 0)); v.wa3m = 4'($urandom_range(3, 0));
    v.wa3w = 4'($urandom_range(3, 0));
    v.rwe = 1'($urandom_range(1, 0)); v.rwm = 1'($urandom_range(1, 0));
    v.rww = 1'($urandom_range(1, 0)); v.m2r = 1'($urandom_range(1, 0));
    v.br  = ($urandom_range(7, 0) == 0);
    v.req = ($urandom_range(2, 0) == 0);
    v.rdy = 1'($urandom_range(1, 0));
    v.clr = ($urandom_range(63, 0) == 0);
    return v;
  endfunction

  initial begin
    vec_t v, z;
    z = '0;
    apply(z, 1'b1);
    apply(z, 1'b1);
    #3;
    cmp("rst_count", int'(bus.stall_count), 0);

    // load r3 in E, add r4,r3,r3 in D; then bubble in E; then add in E with r3 in W
    v = z; v.m2r = 1'b1; v.rwe = 1'b1; v.wa3e = 4'd3; v.ra1d = 4'd3; v.ra2d = 4'd3; v.wa3m = 4'd9;
    apply(v, 1'b0);
    v = z; v.rwm = 1'b1; v.wa3m = 4'd3; v.ra1d = 4'd3; v.ra2d = 4'd3; v.wa3e = 4'd9;
    apply(v, 1'b0);
    v = z; v.rww = 1'b1; v.wa3w = 4'd3; v.ra1e = 4'd3; v.ra2e = 4'd3; v.wa3e = 4'd9; v.wa3m = 4'd9;
    v.ra1d = 4'd7; v.ra2d = 4'd7;
    apply(v, 1'b0);
    #3;
`ifdef HAZARD_FWD_EN
    cmp("lu_count", int'(bus.stall_count), 1);
    cmp("lu_fwd",   int'({bus.ForwardAE, bus.ForwardBE}), 4'b0101);
`else
    cmp("raw_count", int'(bus.stall_count), 2);
    cmp("raw_fwd",   int'({bus.ForwardAE, bus.ForwardBE}), 0);
`endif

    // M beats W for the same source register
    v = z; v.ra1e = 4'd2; v.rwm = 1'b1; v.wa3m = 4'd2; v.rww = 1'b1; v.wa3w = 4'd2; v.wa3e = 4'd9;
    v.ra1d = 4'd7; v.ra2d = 4'd7;
    apply(v, 1'b0);
    v.rwm = 1'b0;
    apply(v, 1'b0);

    // taken branch: resolve cycle plus BRP-1 D-only squashes
    v = z; v.br = 1'b1;
    apply(v, 1'b0);
    repeat (BRP + 1) apply(z, 1'b0);

    // 5-cycle memory wait masking a branch and a load-use, branch flush on release
    v = z; v.req = 1'b1; v.br = 1'b1; v.m2r = 1'b1; v.rwe = 1'b1; v.wa3e = 4'd5; v.ra1d = 4'd5;
    repeat (5) apply(v, 1'b0);
    #3;
    cmp("mw_flush", int'({bus.FlushD, bus.FlushE}), 0);
    v.rdy = 1'b1;
    apply(v, 1'b0);
    #3;
    cmp("mw_release", int'({bus.StallF, bus.FlushD, bus.FlushE}), 3'b011);
    repeat (BRP) apply(z, 1'b0);

    // watchdog: ready never arrives
    v = z; v.req = 1'b1;
    repeat (MTO + 3) apply(v, 1'b0);
    #3;
    cmp("wd_err",   int'(bus.mem_err), 1);
    cmp("wd_stall", int'(bus.StallF), 0);
    apply(z, 1'b1);
    #3;
    cmp("wd_rst", int'({bus.mem_err, bus.stall_count}), 0);
    apply(z, 1'b0);

    // reset in the middle of a squash sequence
    v = z; v.br = 1'b1;
    apply(v, 1'b0);
    apply(z, 1'b1);
    apply(z, 1'b0);
    #3;
    cmp("br_abandon", int'(bus.FlushD), 0);

    // constrained-random phase with occasional reset
    for (int i = 0; i < 3000; i++) begin
      apply(rand_vec(), ($urandom_range(199, 0) == 0));
    end
    apply(z, 1'b0);

    repeat (3) @(posedge clk);
    #5;
    cmp("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
